// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue
//
// Store queue for the data-memory stage. It holds committed stores in a
// circular FIFO until the data cache accepts them. Byte and half stores to the
// word held in the youngest entry are merged into that entry. Loads look up
// every queued entry at once and take each requested byte from the youngest
// entry that holds it.
//
// Ports
//   clk, reset                   clock; synchronous active-high reset
//   st_valid/st_addr/st_data/st_size/st_ready
//                                store request. Data is right-aligned and the
//                                store is accepted on st_valid & st_ready.
//   ld_valid/ld_addr/ld_size     combinational load lookup
//   ld_hit/ld_conflict/ld_data   lookup result. ld_data is shifted to lane 0
//                                and is zero unless ld_hit is set.
//   drain_valid/drain_ready/drain_addr/drain_data/drain_mask
//                                head entry toward the cache write port
//   count, empty                 occupancy
// -----------------------------------------------------------------------------
module store_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [XLEN-1:0]          st_data,
    input  logic [1:0]               st_size,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [1:0]               ld_size,
    output logic                     ld_hit,
    output logic                     ld_conflict,
    output logic [XLEN-1:0]          ld_data,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [ADDR_W-1:0]        drain_addr,
    output logic [XLEN-1:0]          drain_data,
    output logic [XLEN/8-1:0]        drain_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WA  = ADDR_W - OFF;
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Offset forced down to the natural alignment of the access size.
    function automatic logic [OFF-1:0] align_off(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        sz);
        logic [OFF-1:0] o;
        o = a[OFF-1:0];
        case (sz)
            2'b00:   o = a[OFF-1:0];
            2'b01:   o[0] = 1'b0;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Lane enables of an access: size-width ones moved up to the aligned offset.
    function automatic logic [NB-1:0] size_mask(input logic [1:0]     sz,
                                                input logic [OFF-1:0] o);
        logic [NB-1:0] m;
        case (sz)
            2'b00:   m = NB'(1);
            2'b01:   m = NB'(3);
            default: m = '1;
        endcase
        return m << o;
    endfunction

    // Entry storage
    logic [WA-1:0]   waddr_mem [DEPTH];
    logic [XLEN-1:0] data_mem  [DEPTH];
    logic [NB-1:0]   mask_mem  [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;

    // Store-side decode
    logic [OFF-1:0]  st_off;
    logic [NB-1:0]   st_mask;
    logic [XLEN-1:0] st_bmask;
    logic [XLEN-1:0] st_data_sh;
    logic [WA-1:0]   st_waddr;
    logic [PW-1:0]   tail_prev;
    logic            merge_possible;
    logic            st_fire;
    logic            do_merge;
    logic            do_alloc;
    logic            pop;

    assign st_off     = align_off(st_addr, st_size);
    assign st_mask    = size_mask(st_size, st_off);
    assign st_data_sh = st_data << {st_off, 3'b000};
    assign st_waddr   = st_addr[ADDR_W-1:OFF];
    assign tail_prev  = tail_reg - 1'b1;

    // The merge target is the youngest entry; requiring two entries keeps it
    // away from the head, so a merge never races a drain of the same entry.
    assign merge_possible = st_valid && (count_reg >= CNT_TWO)
                            && (waddr_mem[tail_prev] == st_waddr);
    assign st_ready = (count_reg < CNT_FULL) || merge_possible;
    assign st_fire  = st_valid && st_ready;
    assign do_merge = st_fire && merge_possible;
    assign do_alloc = st_fire && !merge_possible;
    assign pop      = drain_valid && drain_ready;

    assign count_next = count_reg + CW'(do_alloc) - CW'(pop);

    // Load-side decode
    logic [OFF-1:0]  ld_off;
    logic [NB-1:0]   ld_mask;
    logic [XLEN-1:0] ld_bmask;
    logic [WA-1:0]   ld_waddr;
    logic [DEPTH-1:0] ent_match;
    logic [NB-1:0]   fwd_cov;
    logic [XLEN-1:0] fwd_data;
    logic [NB-1:0]   req_cov;
    logic            all_cov;

    assign ld_off   = align_off(ld_addr, ld_size);
    assign ld_mask  = size_mask(ld_size, ld_off);
    assign ld_waddr = ld_addr[ADDR_W-1:OFF];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign st_bmask[gi*8 +: 8] = {8{st_mask[gi]}};
            assign ld_bmask[gi*8 +: 8] = {8{ld_mask[gi]}};
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign ent_match[gi] = valid_reg[gi] && (waddr_mem[gi] == ld_waddr);
        end
    endgenerate

    // Walk entries from oldest (head) to youngest. A later hit overwrites an
    // earlier one, so each lane ends up holding the youngest copy of its byte.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_cov  = '0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            for (int b = 0; b < NB; b++) begin
                if (ent_match[idx] && mask_mem[idx][b]) begin
                    fwd_cov[b]          = 1'b1;
                    fwd_data[b*8 +: 8]  = data_mem[idx][b*8 +: 8];
                end
            end
        end
    end

    assign req_cov     = fwd_cov & ld_mask;
    assign all_cov     = (req_cov == ld_mask);
    assign ld_hit      = ld_valid && all_cov;
    assign ld_conflict = ld_valid && (|req_cov) && !all_cov;
    assign ld_data     = ld_hit ? ((fwd_data & ld_bmask) >> {ld_off, 3'b000})
                                : '0;

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (do_alloc) begin
                tail_reg            <= tail_reg + 1'b1;
                valid_reg[tail_reg] <= 1'b1;
            end
            if (pop) begin
                head_reg            <= head_reg + 1'b1;
                valid_reg[head_reg] <= 1'b0;
            end
            count_reg <= count_next;
        end
    end

    // Entry payload; validity is tracked separately so no reset is needed.
    // Allocation stores only the enabled lanes so unused lanes read as zero.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            waddr_mem[tail_reg] <= st_waddr;
            data_mem[tail_reg]  <= st_data_sh & st_bmask;
            mask_mem[tail_reg]  <= st_mask;
        end
        if (do_merge) begin
            data_mem[tail_prev] <= (data_mem[tail_prev] & ~st_bmask)
                                   | (st_data_sh & st_bmask);
            mask_mem[tail_prev] <= mask_mem[tail_prev] | st_mask;
        end
    end

    assign count       = count_reg;
    assign empty       = (count_reg == '0);
    assign drain_valid = !empty;
    assign drain_addr  = {waddr_mem[head_reg], {OFF{1'b0}}};
    assign drain_data  = data_mem[head_reg];
    assign drain_mask  = mask_mem[head_reg];

endmodule

// File: tb/tb_store_queue.sv
// -----------------------------------------------------------------------------
// tb_store_queue
//
// Drives store_queue with directed scenarios followed by random traffic. Each
// cycle the outputs are compared against a byte-level queue model, and a few
// literal expectations pin the model on hand-worked cases.
// -----------------------------------------------------------------------------
module tb_store_queue;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_hit;
    logic        ld_conflict;
    logic [31:0] ld_data;
    logic        drain_valid;
    logic        drain_ready = 1'b0;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_mask;
    logic [2:0]  count;
    logic        empty;

    always #5 clk = ~clk;

    store_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_size(st_size), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_data(ld_data),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_mask(drain_mask), .count(count), .empty(empty)
    );

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  m;
    } ent_t;

    ent_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Values seen in the most recent cycle, for literal checks.
    logic [31:0] obs_ready, obs_count, obs_empty, obs_dvalid;
    logic [31:0] obs_daddr, obs_ddata, obs_dmask;
    logic [31:0] obs_hit, obs_conf, obs_ldata;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // One clock: drive inputs, compare outputs against the model, then advance
    // the model by whatever the DUT is about to accept at the next edge.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [1:0] ss, input logic lv, input logic [31:0] la,
                         input logic [1:0] ls, input logic dr);
        int          nb, cov, lane;
        logic [31:0] sstart, lstart, ba, fdata, exp_ld;
        logic        merge_e, ready_e, pop_e, found, hit_e, conf_e;
        logic [7:0]  bv;
        ent_t        e;

        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; st_size = ss;
        ld_valid = lv; ld_addr = la; ld_size = ls; drain_ready = dr;
        #1;

        nb      = size_bytes(ss);
        sstart  = sa & ~32'(nb - 1);
        merge_e = sv && (q.size() >= 2) && (q[q.size()-1].waddr == sstart[31:2]);
        ready_e = (q.size() < DEPTH) || merge_e;
        pop_e   = (q.size() > 0) && dr;

        check("st_ready", 32'(st_ready), 32'(ready_e));
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("drain_valid", 32'(drain_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("drain_addr", drain_addr, {q[0].waddr, 2'b00});
            check("drain_mask", 32'(drain_mask), 32'(q[0].m));
            check("drain_data", drain_data & bmask(q[0].m), q[0].data & bmask(q[0].m));
        end

        // Forwarding: every requested byte looked up youngest-first.
        hit_e = 1'b0; conf_e = 1'b0; exp_ld = '0; fdata = '0;
        if (lv) begin
            nb     = size_bytes(ls);
            lstart = la & ~32'(nb - 1);
            cov    = 0;
            for (int i = 0; i < nb; i++) begin
                ba    = lstart + 32'(i);
                found = 1'b0;
                bv    = '0;
                for (int k = q.size() - 1; k >= 0; k--) begin
                    if (!found && q[k].waddr == ba[31:2] && q[k].m[ba[1:0]]) begin
                        found = 1'b1;
                        bv    = q[k].data[ba[1:0]*8 +: 8];
                    end
                end
                if (found) begin
                    cov++;
                    fdata[i*8 +: 8] = bv;
                end
            end
            hit_e  = (cov == nb);
            conf_e = (cov > 0) && !hit_e;
            exp_ld = hit_e ? fdata : '0;
        end
        check("ld_hit", 32'(ld_hit), 32'(hit_e));
        check("ld_conflict", 32'(ld_conflict), 32'(conf_e));
        check("ld_data", ld_data, exp_ld);

        obs_ready = 32'(st_ready); obs_count = 32'(count); obs_empty = 32'(empty);
        obs_dvalid = 32'(drain_valid); obs_daddr = drain_addr; obs_ddata = drain_data;
        obs_dmask = 32'(drain_mask); obs_hit = 32'(ld_hit); obs_conf = 32'(ld_conflict);
        obs_ldata = ld_data;

        // Model update for the coming edge.
        if (sv && ready_e) begin
            nb = size_bytes(ss);
            if (merge_e) e = q[q.size()-1];
            else begin
                e.waddr = sstart[31:2];
                e.data  = '0;
                e.m     = '0;
            end
            for (int i = 0; i < nb; i++) begin
                lane = int'(sstart[1:0]) + i;
                e.data[lane*8 +: 8] = sd[i*8 +: 8];
                e.m[lane] = 1'b1;
            end
            if (merge_e) q[q.size()-1] = e;
            else q.push_back(e);
        end
        if (pop_e) void'(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        st_valid = 1'b0; ld_valid = 1'b0; drain_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic dr);
        cycle(1'b1, a, d, sz, 1'b0, 32'h0, 2'b00, dr);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic dr);
        cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, a, sz, dr);
    endtask

    task automatic idle(input logic dr);
        cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, dr);
    endtask

    initial begin
        do_reset();

        // Reset state
        idle(1'b0);
        check("rst_count", obs_count, 32'd0);
        check("rst_empty", obs_empty, 32'd1);
        check("rst_dvalid", obs_dvalid, 32'd0);
        check("rst_ldhit", obs_hit, 32'd0);
        check("rst_ldconf", obs_conf, 32'd0);
        check("rst_lddata", obs_ldata, 32'd0);

        // Store then forward a full word
        st(32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
        ld(32'h100, 2'b10, 1'b0);
        check("fwd_hit", obs_hit, 32'd1);
        check("fwd_data", obs_ldata, 32'hDEADBEEF);
        check("fwd_count", obs_count, 32'd1);
        check("fwd_mask", obs_dmask, 32'hF);

        // Byte merge into the youngest entry
        do_reset();
        st(32'h100, 32'h0, 2'b10, 1'b0);
        st(32'h200, 32'h11, 2'b00, 1'b0);
        st(32'h201, 32'h22, 2'b00, 1'b0);
        idle(1'b1);
        check("merge_count", obs_count, 32'd2);
        check("merge_addr0", obs_daddr, 32'h100);
        check("merge_mask0", obs_dmask, 32'hF);
        idle(1'b1);
        check("merge_addr1", obs_daddr, 32'h200);
        check("merge_data1", obs_ddata, 32'h00002211);
        check("merge_mask1", obs_dmask, 32'h3);

        // Partial overlap
        do_reset();
        st(32'h300, 32'h55, 2'b00, 1'b0);
        ld(32'h300, 2'b10, 1'b0);
        check("po_word_conf", obs_conf, 32'd1);
        check("po_word_hit", obs_hit, 32'd0);
        ld(32'h300, 2'b00, 1'b0);
        check("po_b0_hit", obs_hit, 32'd1);
        check("po_b0_data", obs_ldata, 32'h55);
        ld(32'h301, 2'b00, 1'b0);
        check("po_b1_hit", obs_hit, 32'd0);
        check("po_b1_conf", obs_conf, 32'd0);

        // Youngest wins
        do_reset();
        st(32'h400, 32'h11111111, 2'b10, 1'b0);
        st(32'h500, 32'h0, 2'b10, 1'b0);
        st(32'h400, 32'h22, 2'b00, 1'b0);
        ld(32'h400, 2'b10, 1'b0);
        check("yw_count", obs_count, 32'd3);
        check("yw_hit", obs_hit, 32'd1);
        check("yw_data", obs_ldata, 32'h11111122);

        // Full and pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) st(32'h600 + 32'(4*i), 32'hA0 + 32'(i), 2'b10, 1'b0);
        st(32'h610, 32'hA4, 2'b10, 1'b1);
        check("full_ready", obs_ready, 32'd0);
        check("full_count", obs_count, 32'd4);
        st(32'h610, 32'hA4, 2'b10, 1'b0);
        check("full_count_pop", obs_count, 32'd3);
        check("full_ready_pop", obs_ready, 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (i == 0) check("full_count_re", obs_count, 32'd4);
            check("wrap_order", obs_daddr, 32'h604 + 32'(4*i));
        end

        // Reset with entries outstanding
        do_reset();
        for (int i = 0; i < 3; i++) st(32'h700 + 32'(4*i), 32'h12345678, 2'b10, 1'b0);
        do_reset();
        ld(32'h700, 2'b10, 1'b0);
        check("mr_count", obs_count, 32'd0);
        check("mr_empty", obs_empty, 32'd1);
        check("mr_dvalid", obs_dvalid, 32'd0);
        check("mr_hit", obs_hit, 32'd0);
        check("mr_conf", obs_conf, 32'd0);
        ld(32'h705, 2'b00, 1'b0);
        check("mr_hit_b", obs_hit, 32'd0);
        check("mr_conf_b", obs_conf, 32'd0);

        // Random traffic over a small address window to provoke merges,
        // overlaps and full conditions.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle($urandom_range(0, 9) < 6,
                  32'h100 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3)),
                  $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7,
                  32'h100 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
